phy_rx_align: RTL and testbench
===============================

PHY_RX_ALIGN -- requirements
Module: phy_rx_align

Interface
REQ-001 Parameter IDLE_SYM, default 8'hBC: reserved idle/comma byte; never carried as data.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive aligned idle byte pairs required to declare lock.
REQ-003 clk_32f  input  1: serial bit clock; every flop is clocked on its rising edge.
REQ-004 reset  input  1: synchronous, active-low reset.
REQ-005 data_in_0  input  1: serial lane 0, MSB first; carries data[31:16] (byte 3, then byte 2).
REQ-006 data_in_1  input  1: serial lane 1, MSB first; carries data[15:0] (byte 1, then byte 0).
REQ-007 data_out  output  32: last fully received word; holds its value between words.
REQ-008 valid_out  output  1: one-cycle pulse when data_out takes a new word.
REQ-009 active  output  1: high while the block is LOCKED.
REQ-010 error_out  output  1: one-cycle pulse on a framing error.

Function
REQ-011 Each lane shall shift one bit per cycle into an 8-bit shift register: sr <= {sr[6:0], data_in}.
REQ-012 Both lanes are bit-synchronous and shall share one 3-bit byte-position counter, bit_cnt.
REQ-013 A "byte-complete cycle" is the cycle in which the 8th bit of a byte is sampled; each lane's completed byte is the post-shift value {sr[6:0], data_in}.
REQ-014 The FSM shall have three states: SEARCH, SYNC, LOCKED; reset state is SEARCH.
REQ-015 SEARCH: every cycle, if both lanes' post-shift values equal IDLE_SYM, set bit_cnt to 0, set idle_cnt to 1, and go to SYNC; otherwise stay in SEARCH.
REQ-016 SYNC and LOCKED: bit_cnt increments mod 8 each cycle; a byte-complete cycle is any cycle in which bit_cnt equals 7 before the increment.
REQ-017 SYNC, byte-complete cycle, both lanes IDLE_SYM: idle_cnt increments; when it reaches LOCK_COUNT, go to LOCKED with half-word phase 0.
REQ-018 SYNC, byte-complete cycle, any lane not IDLE_SYM: go to SEARCH and clear idle_cnt; no error pulse.
REQ-019 LOCKED, both lanes IDLE_SYM, phase 0: idle byte; no output change.
REQ-020 LOCKED, both lanes data (neither IDLE_SYM), phase 0: store lane 0 byte as bits [31:24] and lane 1 byte as bits [15:8]; set phase to 1.
REQ-021 LOCKED, both lanes data, phase 1: on the next edge, data_out <= {hi0, lane0 byte, hi1, lane1 byte}, valid_out pulses for 1 cycle, and phase returns to 0.
REQ-022 Latency: valid_out and the new data_out appear exactly 1 cycle after the byte-complete cycle of the word's 16th bit.
REQ-023 LOCKED, both lanes IDLE_SYM, phase 1: discard the half word, pulse error_out, set phase to 0, and stay LOCKED.
REQ-024 LOCKED, one lane IDLE_SYM and the other not (any phase): pulse error_out, discard any partial word, go to SEARCH, and deassert active on the next cycle.
REQ-025 active shall be registered: high the cycle after the LOCKED transition, low the cycle after leaving LOCKED.
REQ-026 A data byte equal to IDLE_SYM is unrepresentable; it shall be treated as idle per REQ-019, REQ-023 and REQ-024.
REQ-027 Outputs shall never be driven by combinational paths from the inputs; all outputs come straight from flops.

Reset
REQ-028 While reset is 0 at a rising edge, the following shall be cleared: data_out=32'h0, valid_out=0, active=0, error_out=0, both shift registers=0, bit_cnt=0, idle_cnt=0, phase=0, state=SEARCH.
REQ-029 Reset asserted in any state, including mid-word, shall take effect at that edge and discard any partial word.
REQ-030 After reset is released, lock requires a fresh SEARCH->SYNC->LOCKED sequence.

Verification
REQ-031 Hold reset=0 for 3 cycles with random lane data -> all outputs 0 every cycle; stay in SEARCH.
REQ-032 After 3 random bits, send 4 aligned 0xBC pairs -> active=1 exactly 1 cycle after the 4th pair's byte-complete cycle. Repeat with 3 pairs then 0x00 -> active stays 0.
REQ-033 Locked; lane0 sends DE,AD and lane1 sends BE,EF -> data_out=32'hDEADBEEF and valid_out=1 for one cycle, 1 cycle after the 16th bit. Back-to-back 32'h01234567 -> valid 16 cycles later.
REQ-034 Locked; lane0 sends BC while lane1 sends 12 -> error_out pulse, active=0 next cycle, no valid_out; relock succeeds with 4 idle pairs.
REQ-035 Locked; send a half word (11/22) then an idle pair -> error_out pulse, no valid_out, active stays 1; the next full word is received correctly.
REQ-036 Assert reset=0 after 10 bits of a word -> next cycle all outputs 0; the word is never delivered.

Source files
------------

// File: rtl/phy_rx_align.sv
// phy_rx_align: two-lane serial receiver that aligns on idle byte pairs
// and assembles 32-bit words once enough aligned idle pairs have been seen.
module phy_rx_align #(
    parameter logic [7:0] IDLE_SYM   = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in_0,
    input  logic        data_in_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active,
    output logic        error_out
);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [7:0]    sr0_q, sr1_q, hi0_q, hi0_d, hi1_q, hi1_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
    logic          phase_q, phase_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d, err_q, err_d, active_q;
    logic [7:0]    p0, p1;
    logic          i0, i1, byte_done;

    assign p0        = {sr0_q[6:0], data_in_0};
    assign p1        = {sr1_q[6:0], data_in_1};
    assign i0        = p0 == IDLE_SYM;
    assign i1        = p1 == IDLE_SYM;
    assign byte_done = bit_cnt_q == 3'd7;
    assign idle_inc  = idle_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        idle_cnt_d = idle_cnt_q;
        phase_d    = phase_q;
        hi0_d      = hi0_q;
        hi1_d      = hi1_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            SEARCH: begin
                // the counter only runs once an alignment candidate is found
                bit_cnt_d = bit_cnt_q;
                if (i0 && i1) begin
                    bit_cnt_d  = 3'd0;
                    idle_cnt_d = CW'(1);
                    phase_d    = 1'b0;
                    state_d    = (LOCK_COUNT <= 1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (byte_done) begin
                    if (i0 && i1) begin
                        idle_cnt_d = idle_inc;
                        if (idle_inc == CW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            phase_d = 1'b0;
                        end
                    end else begin
                        state_d    = SEARCH;
                        idle_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (byte_done) begin
                    if (i0 != i1) begin
                        err_d      = 1'b1;
                        state_d    = SEARCH;
                        phase_d    = 1'b0;
                        idle_cnt_d = '0;
                    end else if (i0) begin
                        err_d   = phase_q;
                        phase_d = 1'b0;
                    end else if (!phase_q) begin
                        hi0_d   = p0;
                        hi1_d   = p1;
                        phase_d = 1'b1;
                    end else begin
                        data_d  = {hi0_q, p0, hi1_q, p1};
                        valid_d = 1'b1;
                        phase_d = 1'b0;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q    <= SEARCH;
            sr0_q      <= '0;
            sr1_q      <= '0;
            hi0_q      <= '0;
            hi1_q      <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            phase_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr0_q      <= p0;
            sr1_q      <= p1;
            hi0_q      <= hi0_d;
            hi1_q      <= hi1_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            phase_q    <= phase_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            active_q   <= state_d == LOCKED;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign error_out = err_q;
    assign active    = active_q;
endmodule

// File: tb/tb_phy_rx_align.sv
// tb_phy_rx_align: randomized and directed checks of phy_rx_align against a
// byte/queue level reference model.
module tb_phy_rx_align;
    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         LOCK = 4;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b0;
    logic        data_in_0 = 1'b0;
    logic        data_in_1 = 1'b0;
    logic [31:0] data_out;
    logic        valid_out, active, error_out;

    int errors = 0;
    int checks = 0;

    int          ms, since, nidle;
    logic [7:0]  w0, w1;
    logic [7:0]  q0[$], q1[$];
    logic [31:0] m_data;
    logic        m_valid, m_act, m_err;
    logic [34:0] obs[$], expv[$];

    phy_rx_align #(.IDLE_SYM(IDLE), .LOCK_COUNT(LOCK)) dut (
        .clk_32f(clk_32f), .reset(reset), .data_in_0(data_in_0), .data_in_1(data_in_1),
        .data_out(data_out), .valid_out(valid_out), .active(active), .error_out(error_out)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic model(input logic r, input logic b0, input logic b1);
        logic a0, a1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!r) begin
            ms = 0; since = 0; nidle = 0; w0 = '0; w1 = '0;
            q0.delete(); q1.delete(); m_data = '0; m_act = 1'b0;
            return;
        end
        w0 = {w0[6:0], b0};
        w1 = {w1[6:0], b1};
        a0 = w0 == IDLE;
        a1 = w1 == IDLE;
        if (ms == 0) begin
            if (a0 && a1) begin ms = 1; since = 0; nidle = 1; end
        end else begin
            since++;
            if (since % 8 == 0) begin
                if (ms == 1) begin
                    if (a0 && a1) begin
                        nidle++;
                        if (nidle >= LOCK) begin ms = 2; q0.delete(); q1.delete(); end
                    end else begin
                        ms = 0; nidle = 0;
                    end
                end else if (a0 != a1) begin
                    m_err = 1'b1; ms = 0; q0.delete(); q1.delete();
                end else if (a0) begin
                    if (q0.size() != 0) m_err = 1'b1;
                    q0.delete(); q1.delete();
                end else begin
                    q0.push_back(w0);
                    q1.push_back(w1);
                    if (q0.size() == 2) begin
                        m_data  = {q0[0], q0[1], q1[0], q1[1]};
                        m_valid = 1'b1;
                        q0.delete(); q1.delete();
                    end
                end
            end
        end
        m_act = ms == 2;
    endtask

    task automatic step(input logic r, input logic b0, input logic b1);
        reset = r; data_in_0 = b0; data_in_1 = b1;
        @(posedge clk_32f);
        model(r, b0, b1);
        #1;
        obs.push_back({data_out, valid_out, active, error_out});
        expv.push_back({m_data, m_valid, m_act, m_err});
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(1'b1, a[i], b[i]);
    endtask

    task automatic lock();
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < LOCK; k++) send(IDLE, IDLE);
        obs.delete(); expv.delete();
    endtask

    function automatic logic [7:0] rnd_data();
        logic [7:0] b;
        b = 8'($urandom);
        return (b == IDLE) ? 8'h00 : b;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'($urandom), 1'($urandom));
            checks++;
            if ({data_out, valid_out, active, error_out} !== 35'h0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h want 0", k, {data_out, valid_out, active, error_out});
            end
        end
    endtask

    task automatic test_lock();
        logic [34:0] v, u;
        obs.delete(); expv.delete();
        for (int k = 0; k < 3; k++) step(1'b1, 1'($urandom), 1'($urandom));
        for (int k = 0; k < 4; k++) send(IDLE, IDLE);
        foreach (obs[k]) begin
            checks++;
            if (obs[k] !== expv[k]) begin errors++; $display("FAIL lock cyc%0d: got %h want %h", k, obs[k], expv[k]); end
        end
        v = obs[34]; u = obs[33];
        checks++;
        if (v[1] !== 1'b1 || u[1] !== 1'b0) begin
            errors++; $display("FAIL lock_edge: active got %b,%b want 0,1", u[1], v[1]);
        end
        step(1'b0, 1'b0, 1'b0);
        obs.delete(); expv.delete();
        for (int k = 0; k < 3; k++) send(IDLE, IDLE);
        send(8'h00, 8'h00);
        send(8'h00, 8'h00);
        foreach (obs[k]) begin
            v = obs[k];
            checks++;
            if (obs[k] !== expv[k] || v[1] !== 1'b0) begin
                errors++; $display("FAIL nolock cyc%0d: got %h want %h", k, obs[k], expv[k]);
            end
        end
    endtask

    task automatic test_word();
        logic [34:0] v;
        int nv;
        lock();
        send(8'hDE, 8'hBE); send(8'hAD, 8'hEF);
        send(8'h01, 8'h45); send(8'h23, 8'h67);
        send(IDLE, IDLE);
        nv = 0;
        foreach (obs[k]) begin
            v = obs[k];
            nv += int'(v[2]);
            checks++;
            if (obs[k] !== expv[k]) begin errors++; $display("FAIL word cyc%0d: got %h want %h", k, obs[k], expv[k]); end
        end
        v = obs[15];
        checks++;
        if (v[2] !== 1'b1 || v[34:3] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word1: valid %b data %h want 1 DEADBEEF", v[2], v[34:3]);
        end
        v = obs[31];
        checks++;
        if (v[2] !== 1'b1 || v[34:3] !== 32'h01234567) begin
            errors++; $display("FAIL word2: valid %b data %h want 1 01234567", v[2], v[34:3]);
        end
        checks++;
        if (nv != 2) begin errors++; $display("FAIL word_count: got %0d want 2", nv); end
    endtask

    task automatic test_mismatch();
        logic [34:0] v, u;
        lock();
        send(IDLE, 8'h12);
        for (int k = 0; k < 4; k++) send(IDLE, IDLE);
        foreach (obs[k]) begin
            v = obs[k];
            checks++;
            if (obs[k] !== expv[k] || v[2] !== 1'b0) begin
                errors++; $display("FAIL mismatch cyc%0d: got %h want %h", k, obs[k], expv[k]);
            end
        end
        v = obs[7]; u = obs[6];
        checks++;
        if (v[0] !== 1'b1 || v[1] !== 1'b0 || u[1] !== 1'b1) begin
            errors++; $display("FAIL mismatch_err: err %b act %b prev act %b want 1 0 1", v[0], v[1], u[1]);
        end
        v = obs[39]; u = obs[38];
        checks++;
        if (v[1] !== 1'b1 || u[1] !== 1'b0) begin
            errors++; $display("FAIL relock: active got %b,%b want 0,1", u[1], v[1]);
        end
    endtask

    task automatic test_half_word();
        logic [34:0] v;
        logic [7:0]  r0, r1, r2, r3;
        int nv, ne;
        r0 = rnd_data(); r1 = rnd_data(); r2 = rnd_data(); r3 = rnd_data();
        lock();
        send(8'h11, 8'h22); send(IDLE, IDLE);
        send(r0, r2); send(r1, r3);
        send(IDLE, IDLE);
        nv = 0; ne = 0;
        foreach (obs[k]) begin
            v = obs[k];
            nv += int'(v[2]); ne += int'(v[0]);
            checks++;
            if (obs[k] !== expv[k] || v[1] !== 1'b1) begin
                errors++; $display("FAIL half cyc%0d: got %h want %h", k, obs[k], expv[k]);
            end
        end
        v = obs[15];
        checks++;
        if (v[0] !== 1'b1 || v[2] !== 1'b0) begin
            errors++; $display("FAIL half_err: err %b valid %b want 1 0", v[0], v[2]);
        end
        v = obs[31];
        checks++;
        if (v[2] !== 1'b1 || v[34:3] !== {r0, r1, r2, r3}) begin
            errors++; $display("FAIL half_next: valid %b data %h want 1 %h", v[2], v[34:3], {r0, r1, r2, r3});
        end
        checks++;
        if (nv != 1 || ne != 1) begin errors++; $display("FAIL half_count: valid %0d err %0d want 1 1", nv, ne); end
    endtask

    task automatic test_reset_mid();
        logic [34:0] v;
        logic [7:0]  a, b;
        int nv;
        a = 8'h33; b = 8'h44;
        lock();
        send(8'hA1, 8'hB2);
        step(1'b1, a[7], b[7]);
        step(1'b1, a[6], b[6]);
        step(1'b0, a[5], b[5]);
        for (int i = 4; i >= 0; i--) step(1'b1, a[i], b[i]);
        send(8'h00, 8'h00); send(8'h00, 8'h00);
        nv = 0;
        foreach (obs[k]) begin
            v = obs[k];
            nv += int'(v[2]);
            checks++;
            if (obs[k] !== expv[k]) begin errors++; $display("FAIL rstmid cyc%0d: got %h want %h", k, obs[k], expv[k]); end
        end
        v = obs[10];
        checks++;
        if (v !== 35'h0) begin errors++; $display("FAIL rstmid_clear: got %h want 0", v); end
        checks++;
        if (nv != 0) begin errors++; $display("FAIL rstmid_valid: got %0d want 0", nv); end
    endtask

    task automatic test_random();
        int kind;
        lock();
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) send(rnd_data(), rnd_data());
            else if (kind == 6) send(IDLE, IDLE);
            else if (kind == 7) for (int k = 0; k < LOCK; k++) send(IDLE, IDLE);
            else if (kind == 8) begin
                if ($urandom_range(0, 1) == 1) send(IDLE, rnd_data());
                else send(rnd_data(), IDLE);
            end else step(1'b1, 1'($urandom), 1'($urandom));
        end
        foreach (obs[k]) begin
            checks++;
            if (obs[k] !== expv[k]) begin errors++; $display("FAIL random cyc%0d: got %h want %h", k, obs[k], expv[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_word();
        test_mismatch();
        test_half_word();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
